// File: rtl/mdu_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] mdu_src1;
  logic [WIDTH-1:0] mdu_src2;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] mdu_res;
  logic             res_zero;

  modport master (
    output flush, req_valid, mdu_op, mdu_src1, mdu_src2, res_ready,
    input  req_ready, res_valid, mdu_res, res_zero
  );

  modport slave (
    input  flush, req_valid, mdu_op, mdu_src1, mdu_src2, res_ready,
    output req_ready, res_valid, mdu_res, res_zero
  );
endinterface

// File: rtl/mdu.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over WIDTH cycles, with a one-cycle path for divide-by-zero and signed overflow.
module mdu #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               signA_q, signA_d;
  logic               signB_q, signB_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   mduRes_q, mduRes_d;

  logic               reqReady;
  logic               s1Signed, s2Signed, negA, negB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH-1:0]   minNeg;
  logic [WIDTH:0]     mulSum, divTrial;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quoFixed, remFixed;

  assign minNeg   = {1'b1, {(WIDTH-1){1'b0}}};
  assign reqReady = (state_q == IDLE) && !bus.flush;

  assign s1Signed = (bus.mdu_op == 3'b001) || (bus.mdu_op == 3'b010) ||
                    (bus.mdu_op == 3'b100) || (bus.mdu_op == 3'b110);
  assign s2Signed = (bus.mdu_op == 3'b001) || (bus.mdu_op == 3'b100) ||
                    (bus.mdu_op == 3'b110);
  assign negA     = s1Signed && bus.mdu_src1[WIDTH-1];
  assign negB     = s2Signed && bus.mdu_src2[WIDTH-1];
  assign magA     = negA ? -bus.mdu_src1 : bus.mdu_src1;
  assign magB     = negB ? -bus.mdu_src2 : bus.mdu_src2;

  // work_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  assign mulSum    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign divTrial  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} - {1'b0, opnd_q};
  assign prodFixed = (signA_q ^ signB_q) ? -work_q : work_q;
  assign quoFixed  = (signA_q ^ signB_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign remFixed  = signA_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    signA_d  = signA_q;
    signB_d  = signB_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    mduRes_d = mduRes_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && reqReady) begin
          op_d    = bus.mdu_op;
          signA_d = negA;
          signB_d = negB;
          if (bus.mdu_op[2] && (bus.mdu_src2 == '0)) begin
            mduRes_d = bus.mdu_op[1] ? bus.mdu_src1 : '1;
            state_d  = DONE;
          end else if (bus.mdu_op[2] && !bus.mdu_op[0] &&
                       (bus.mdu_src1 == minNeg) && (bus.mdu_src2 == '1)) begin
            mduRes_d = bus.mdu_op[1] ? '0 : bus.mdu_src1;
            state_d  = DONE;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH);
            if (bus.mdu_op[2]) begin
              work_d = {{WIDTH{1'b0}}, magA};
              opnd_d = magB;
            end else begin
              work_d = {{WIDTH{1'b0}}, magB};
              opnd_d = magA;
            end
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[2]) begin
          // A borrow means the trial subtraction failed: keep the shifted remainder.
          work_d = divTrial[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                   : {divTrial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        end else begin
          work_d = {mulSum, work_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[2])                  mduRes_d = op_q[1] ? remFixed : quoFixed;
        else if (op_q[1:0] == 2'b00)  mduRes_d = prodFixed[WIDTH-1:0];
        else                          mduRes_d = prodFixed[2*WIDTH-1:WIDTH];
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      signA_q  <= 1'b0;
      signB_q  <= 1'b0;
      work_q   <= '0;
      opnd_q   <= '0;
      mduRes_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      signA_q  <= signA_d;
      signB_q  <= signB_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      mduRes_q <= mduRes_d;
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.res_valid = (state_q == DONE);
  assign bus.mdu_res   = mduRes_q;
  assign bus.res_zero  = (state_q == DONE) && (mduRes_q == '0);
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed RV32M cases, handshake/abort scenarios
// and randomized operations against an arithmetic reference model.
module tb_mdu;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction with res_ready held high; checks latency, result and return to idle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    logic [31:0] exp;
    int          lat, cyc;
    exp = refModel(op, a, b);
    lat = (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : W + 2;
    bus.mdu_op    = op;
    bus.mdu_src1  = a;
    bus.mdu_src2  = b;
    bus.req_valid = 1'b1;
    #1 checkOutput({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mdu_src1  = $urandom;
    bus.mdu_src2  = $urandom;
    bus.mdu_op    = 3'($urandom_range(0, 7));
    cyc = 1;
    while (!bus.res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(lat));
    checkOutput({tag, "_res"}, bus.mdu_res, exp);
    checkOutput({tag, "_zero"}, {31'b0, bus.res_zero}, {31'b0, exp == 0});
    @(negedge clk);
    checkOutput({tag, "_idle"}, {30'b0, bus.req_ready, bus.res_valid}, 32'd2);
  endtask

  initial begin
    int          cyc;
    int          seen;
    logic [31:0] held;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.mdu_op    = '0;
    bus.mdu_src1  = '0;
    bus.mdu_src2  = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    checkOutput("rst_res_zero", {31'b0, bus.res_zero}, 32'd0);
    checkOutput("rst_mdu_res", bus.mdu_res, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] fast paths");
    applyStimulus(3'd5, 32'd7, 32'd0, "divu_by0");
    applyStimulus(3'd7, 32'd7, 32'd0, "remu_by0");
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd0, "div_by0");
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd0, "rem_by0");

    $display("[TB] multiply high halves");
    applyStimulus(3'd0, 32'hFFFFFFFF, 32'd2, "mul");
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2, "mulh");
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'd2, "mulhu");
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'd2, "mulhsu");
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, "mulh_minmin");

    $display("[TB] divide and remainder");
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, "div_neg");
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, "rem_neg");
    applyStimulus(3'd5, 32'd100, 32'd7, "divu");
    applyStimulus(3'd7, 32'd100, 32'd7, "remu");
    applyStimulus(3'd4, 32'h80000000, 32'd3, "div_min");

    $display("[TB] idle flush blocks request");
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.mdu_op    = 3'd5;
    bus.mdu_src1  = 32'd7;
    bus.mdu_src2  = 32'd0;
    #1 checkOutput("flush_idle_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1 checkOutput("flush_idle_noacc", {30'b0, bus.req_ready, bus.res_valid}, 32'd2);
    @(negedge clk);

    $display("[TB] handshake stress");
    bus.res_ready = 1'b0;
    bus.mdu_op    = 3'd0;
    bus.mdu_src1  = 32'h1234;
    bus.mdu_src2  = 32'h10;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.mdu_op = 3'd5;
    bus.mdu_src2 = 32'd0;
    checkOutput("busy_ready", {31'b0, bus.req_ready}, 32'd0);
    cyc = 1;
    while (!bus.res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("stress_latency", 32'(cyc), 32'(W + 2));
    held = bus.mdu_res;
    checkOutput("stress_res", held, 32'h12340);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stress_hold_res", bus.mdu_res, 32'h12340);
      checkOutput("stress_hold_flags", {30'b0, bus.req_ready, bus.res_valid}, 32'd1);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    checkOutput("stress_release", {30'b0, bus.req_ready, bus.res_valid}, 32'd2);
    @(negedge clk);
    checkOutput("stress_no_phantom", {30'b0, bus.req_ready, bus.res_valid}, 32'd2);

    $display("[TB] flush abort");
    bus.mdu_op    = 3'd5;
    bus.mdu_src1  = 32'hDEADBEEF;
    bus.mdu_src2  = 32'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1 checkOutput("flush_abort_idle", {30'b0, bus.req_ready, bus.res_valid}, 32'd2);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    checkOutput("flush_abort_noresult", 32'(seen), 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd5, "post_flush_mul");

    $display("[TB] reset abort");
    bus.mdu_op    = 3'd5;
    bus.mdu_src1  = 32'hDEADBEEF;
    bus.mdu_src2  = 32'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rst_abort_idle", {29'b0, bus.res_zero, bus.req_ready, bus.res_valid}, 32'd2);
    checkOutput("rst_abort_res", bus.mdu_res, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    checkOutput("rst_abort_noresult", 32'(seen), 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd5, "post_rst_mul");

    $display("[TB] randomized operations");
    for (int i = 0; i < 48; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(op, a, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
